conv_enc_frame_ctrl: RTL and testbench
======================================

// Module: conv_enc_frame_ctrl
// PURPOSE
//  Frame sequencer for the K=5, rate-1/2 convolutional encoder.
//  - Accepts payload bytes over a valid/ready handshake and serialises them MSB-first into an internal encoder sub-module.
//  - Terminates the trellis with zero tail bits.
//  - Presents each coded bit-pair on a registered valid/ready output with backpressure.
//  - Sits between the byte-level host logic and the serial line driver.
// PARAMETERS
//  LEN_W     8        width of frame_len (bytes per frame, 1..2^LEN_W-1)
//  TAIL_LEN  4        zero tail bits appended per frame (K-1)
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      synchronous reset, active low
//  start       in   1      frame start pulse; sampled only in IDLE
//  frame_len   in   LEN_W  payload bytes; latched when start is accepted
//  byte_data   in   8      payload byte
//  byte_valid  in   1      byte_data valid
//  byte_ready  out  1      controller accepts a byte this cycle
//  enc_dout    out  2      coded pair: [1]=G1 parity, [0]=G2 parity
//  enc_valid   out  1      enc_dout valid; held until enc_ready
//  enc_ready   in   1      downstream accepts enc_dout
//  busy        out  1      high in every state except IDLE
//  frame_done  out  1      one-cycle pulse after the last pair is accepted
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE.
//    - Outputs: byte_ready=0, enc_valid=0, enc_dout=0, busy=0, frame_done=0.
//    - Shift register, bit counter and byte counter all cleared.
//    - Reset mid-frame aborts the frame; no further pairs are emitted.
//  - FSM states: IDLE, LOAD, SHIFT, TAIL, DONE.
//  - IDLE:
//    - start=1 and frame_len!=0: latch frame_len, clear the encoder shift register, go to LOAD.
//    - start with frame_len=0 is ignored (stay in IDLE).
//  - LOAD: byte_ready=1. On byte_valid&byte_ready, capture the byte and go to SHIFT with bit index 7.
//  - Advance condition: adv = (SHIFT|TAIL) & (~enc_valid | enc_ready).
//  - On each adv:
//    - Shift the bit in: sr <= {bit, sr[4:1]}.
//    - Register enc_dout <= {^(G1 & sr_next), ^(G2 & sr_next)} and set enc_valid=1.
//    - The bit is byte[idx] in SHIFT and 0 in TAIL.
//  - If enc_valid&enc_ready occurs without adv, enc_valid clears to 0.
//  - SHIFT, after bit 0:
//    - Bytes remain: go to LOAD.
//    - Last byte: go to TAIL (CONV_ENC_TAIL_EN) or DONE.
//  - TAIL: after TAIL_LEN advances, go to DONE.
//  - DONE:
//    - Wait until enc_valid=0, or enc_valid&enc_ready this cycle.
//    - Then pulse frame_done for 1 cycle and return to IDLE.
//  - Latency: first enc_valid appears 2 cycles after the byte handshake cycle.
//  - Throughput: 1 pair/cycle within a byte while enc_ready=1. Each inter-byte LOAD costs >=1 bubble cycle.
//  - enc_dout and enc_valid are stable while enc_valid=1 and enc_ready=0.
//  - start while busy=1 is ignored.
//  - byte_valid deasserted in LOAD: wait indefinitely; the encoder state is held.
//  - Counters never wrap. Byte counter range is 1..frame_len; bit index range is 7..0.
// CONFIGURATION
//  CONV_ENC_TAIL_EN
//    - Defined: TAIL state emits TAIL_LEN zero-input pairs. Pairs per frame = 8*frame_len+TAIL_LEN.
//    - Undefined: TAIL state is never entered (SHIFT goes to DONE). Pairs per frame = 8*frame_len; the trellis is left unterminated.
// STRUCTURE
//  - conv_enc_pkg:
//    - G1=5'b10111, G2=5'b11001, K=5.
//    - State enum typedef.
//    - Function parity_pair(sr) returning {^(G1&sr), ^(G2&sr)}.
//  - Sub-module conv_enc_k5_core:
//    - 5-bit shift register with shift_en, sync clear and bit_in.
//    - Drives the combinational next-pair.
//  - FSM, counters and the output register live in conv_enc_frame_ctrl.
// TESTING
//  1. TAIL_EN, frame_len=1, byte 0x80, enc_ready=1 -> 12 pairs: 11,01,10,10,11, then 7x 00; single frame_done.
//  2. No TAIL_EN, same stimulus -> 8 pairs: 11,01,10,10,11,00,00,00; frame_done one cycle after the last accept.
//  3. frame_len=2, bytes 0xFF,0x00, enc_ready toggling 1/0 -> no pair lost or duplicated; dout stable while stalled; 20 pairs.
//  4. start with frame_len=0, and start while busy -> no state change; busy unchanged; no pairs.
//  5. rst_n=0 for 1 cycle mid-SHIFT -> next cycle all outputs 0; state IDLE; a new frame starts with sr=0.
//  6. byte_valid held low 10 cycles in LOAD -> byte_ready=1 throughout; enc_valid drops after the pending accept; resumes correctly.

Source files
------------

// File: rtl/conv_enc_pkg.sv
// Shared constants, FSM state encoding and the parity helper for the K=5, rate-1/2 encoder.
package conv_enc_pkg;

  localparam int K = 5;
  localparam logic [K-1:0] G1 = 5'b10111;
  localparam logic [K-1:0] G2 = 5'b11001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_TAIL,
    S_DONE
  } state_t;

  // sr[K-1] holds the newest input bit.
  function automatic logic [1:0] parity_pair(input logic [K-1:0] sr);
    return {^(G1 & sr), ^(G2 & sr)};
  endfunction

endpackage

// File: rtl/conv_enc_k5_core.sv
// K=5 encoder shift register; o_pair is the coded pair the register would produce if i_bit shifted in now.
module conv_enc_k5_core
  import conv_enc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_shift_en,
  input  logic       i_bit,
  output logic [1:0] o_pair
);

  logic [K-1:0] r_sr;
  logic [K-1:0] w_sr_next;

  assign w_sr_next = {i_bit, r_sr[K-1:1]};
  assign o_pair    = parity_pair(w_sr_next);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_sr <= '0;
    end else if (i_shift_en) begin
      r_sr <= w_sr_next;
    end
  end

endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer: bytes in over valid/ready, MSB-first into the K=5 core, coded pairs out on a registered valid/ready stage.
// Define CONV_ENC_TAIL_EN to terminate each frame with TAIL_LEN zero-input pairs.
module conv_enc_frame_ctrl
  import conv_enc_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int TAIL_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic [7:0]       i_byte_data,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic [1:0]       o_enc_dout,
  output logic             o_enc_valid,
  input  logic             i_enc_ready,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_byte_cnt;
  logic [2:0]       r_bit_idx;
  logic [TW-1:0]    r_tail_cnt;
  logic [7:0]       r_byte;
  logic [1:0]       r_dout;
  logic             r_valid;
  logic             r_done;

  logic             w_adv;
  logic             w_bit;
  logic             w_clr;
  logic             w_start_ok;
  logic             w_load_hs;
  logic             w_drain_ok;
  logic             w_last_byte;
  logic             w_last_tail;
  logic [1:0]       w_pair;

  // The output stage may take a new pair when empty or when its current pair leaves this cycle.
  assign w_drain_ok  = ~r_valid | i_enc_ready;
  assign w_adv       = ((r_state == S_SHIFT) || (r_state == S_TAIL)) && w_drain_ok;
  assign w_bit       = (r_state == S_SHIFT) ? r_byte[r_bit_idx] : 1'b0;
  assign w_start_ok  = i_start && (i_frame_len != '0);
  assign w_clr       = (r_state == S_IDLE) && w_start_ok;
  assign w_load_hs   = (r_state == S_LOAD) && i_byte_valid;
  assign w_last_byte = (r_byte_cnt == r_len);
  assign w_last_tail = (r_tail_cnt == TW'(TAIL_LEN - 1));

  conv_enc_k5_core u_core (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_clr),
    .i_shift_en (w_adv),
    .i_bit      (w_bit),
    .o_pair     (w_pair)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_LOAD;
      S_LOAD:  if (i_byte_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_adv && (r_bit_idx == 3'd0)) begin
          if (!w_last_byte) begin
            w_state_nxt = S_LOAD;
          end else begin
`ifdef CONV_ENC_TAIL_EN
            w_state_nxt = S_TAIL;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
      S_TAIL:  if (w_adv && w_last_tail) w_state_nxt = S_DONE;
      S_DONE:  if (w_drain_ok) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_bit_idx  <= '0;
      r_tail_cnt <= '0;
      r_byte     <= '0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_DONE) && w_drain_ok;

      if (w_clr) begin
        r_len      <= i_frame_len;
        r_byte_cnt <= LEN_W'(1);
        r_tail_cnt <= '0;
      end

      if (w_load_hs) begin
        r_byte    <= i_byte_data;
        r_bit_idx <= 3'd7;
      end

      if (w_adv) begin
        r_dout  <= w_pair;
        r_valid <= 1'b1;
        if (r_state == S_SHIFT) begin
          if (r_bit_idx != 3'd0) begin
            r_bit_idx <= r_bit_idx - 3'd1;
          end else if (!w_last_byte) begin
            r_byte_cnt <= r_byte_cnt + LEN_W'(1);
          end
        end else if (!w_last_tail) begin
          r_tail_cnt <= r_tail_cnt + TW'(1);
        end
      end else if (r_valid && i_enc_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_byte_ready = (r_state == S_LOAD);
  assign o_enc_dout   = r_dout;
  assign o_enc_valid  = r_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_done;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Directed bench for conv_enc_frame_ctrl; expected pair streams are hand-computed for G1=10111, G2=11001.
module tb_conv_enc_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] frame_len;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic [1:0] enc_dout;
  logic       enc_valid;
  logic       enc_ready;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

`ifdef CONV_ENC_TAIL_EN
  localparam int TAILN = 4;
`else
  localparam int TAILN = 0;
`endif

  logic [7:0] bytes [4];
  logic [1:0] got [$];
  logic [1:0] expq [$];
  // 0x80 followed by zeros, and 0xFF,0x00 followed by zeros; later pairs are all 00.
  logic [1:0] pat80 [5]  = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [1:0] patff [13] = '{2'd3, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1,
                             2'd2, 2'd3, 2'd1, 2'd3, 2'd0};
  int   ndone;
  int   last_acc;
  int   done_cyc;
  logic done_seen;

  always #5 clk = ~clk;

  conv_enc_frame_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_frame_len  (frame_len),
    .i_byte_data  (byte_data),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .o_enc_dout   (enc_dout),
    .o_enc_valid  (enc_valid),
    .i_enc_ready  (enc_ready),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic build_exp(input int n, input bit use_ff);
    expq.delete();
    for (int i = 0; i < n; i++) begin
      if (use_ff) expq.push_back((i < 13) ? patff[i] : 2'd0);
      else        expq.push_back((i < 5) ? pat80[i] : 2'd0);
    end
  endtask

  task automatic check_pairs(input string tag);
    chk({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      chk(tag, (i < got.size()) ? got[i] : 2'bxx, expq[i]);
    end
  endtask

  // Runs one frame from IDLE; gap holds byte_valid low for that many cycles in the second LOAD
  // while pulsing start with a different length.
  task automatic run_frame(input int len, input bit toggle, input int gap, input int max_cyc);
    int         bi;
    int         cyc;
    int         gap_k;
    logic       prev_stall;
    logic [1:0] prev_d;
    got.delete();
    ndone = 0; last_acc = -1; done_cyc = -1; done_seen = 1'b0;
    bi = 0; cyc = 0; gap_k = 0; prev_stall = 1'b0; prev_d = 2'd0;
    frame_len = len[7:0];
    start = 1'b1;
    step();
    start = 1'b0;
    while (!done_seen && cyc < max_cyc) begin
      enc_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (bi == 1 && gap_k < gap && (gap_k > 0 || byte_ready)) begin
        byte_valid = 1'b0;
        start      = 1'b1;
        frame_len  = 8'd5;
        chk("gap_byte_ready", byte_ready, 1);
        chk("gap_busy", busy, 1);
        if (gap_k > 0) chk("gap_enc_valid", enc_valid, 0);
        gap_k++;
      end else begin
        start      = 1'b0;
        byte_valid = (bi < len);
        byte_data  = bytes[bi];
      end
      if (byte_ready && byte_valid) bi++;
      if (enc_valid && enc_ready) begin
        got.push_back(enc_dout);
        last_acc = cyc;
      end
      prev_stall = enc_valid && !enc_ready;
      prev_d     = enc_dout;
      step();
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", enc_valid, 1);
        chk("stall_dout", enc_dout, prev_d);
      end
      if (frame_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        ndone++;
      end
    end
    start = 1'b0; byte_valid = 1'b0; enc_ready = 1'b1;
    chk("frame_timeout", done_seen, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (frame_done) ndone++;
    end
    chk("frame_done_count", ndone, 1);
    chk("idle_after_frame", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_len = 8'd0; byte_data = 8'd0;
    byte_valid = 1'b0; enc_ready = 1'b1;
    bytes = '{8'h80, 8'h00, 8'h00, 8'h00};
    step();
    step();
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_enc_valid", enc_valid, 0);
    chk("rst_enc_dout", enc_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    step();

    // Single byte 0x80, always ready.
    build_exp(8 + TAILN, 1'b0);
    run_frame(1, 1'b0, 0, 100);
    check_pairs("f80");
    chk("done_latency", done_cyc, last_acc + 1);

    // Two bytes 0xFF,0x00 under alternating backpressure.
    bytes[0] = 8'hFF; bytes[1] = 8'h00;
    build_exp(16 + TAILN, 1'b1);
    run_frame(2, 1'b1, 0, 300);
    check_pairs("fff00");

    // Zero-length start is ignored.
    frame_len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_busy", busy, 0);
    chk("len0_byte_ready", byte_ready, 0);
    step();
    chk("len0_enc_valid", enc_valid, 0);

    // Stalled byte source in LOAD plus a start pulse while busy.
    bytes[0] = 8'h80; bytes[1] = 8'h00;
    build_exp(16 + TAILN, 1'b0);
    run_frame(2, 1'b0, 10, 300);
    check_pairs("gap");

    // Reset mid-SHIFT.
    frame_len = 8'd1; start = 1'b1;
    step();
    start = 1'b0; byte_data = 8'hFF; byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
    step();
    step();
    chk("pre_rst_enc_valid", enc_valid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_byte_ready", byte_ready, 0);
    chk("mid_rst_enc_valid", enc_valid, 0);
    chk("mid_rst_enc_dout", enc_dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_quiet_valid", enc_valid, 0);
      chk("post_rst_quiet_busy", busy, 0);
    end
    bytes[0] = 8'h80;
    build_exp(8 + TAILN, 1'b0);
    run_frame(1, 1'b0, 0, 100);
    check_pairs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
